wb_dma_copy: RTL

- Pipelined-Wishbone bus initiator; copies a block of 32-bit words from a source word address to a destination word address.
- Sits beside the core as a second bus master, behind the system arbiter, and reaches the same slaves: SRAM and SSEG.
- Started by a one-cycle pulse; reports completion with a one-cycle done pulse and a sticky error flag.

---
 rtl/wb_dma_copy.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_dma_copy.sv
// Pipelined-Wishbone block copier: reads one word, writes it back out, and releases
// the bus for one cycle between words. Define WB_DMA_TIMEOUT_EN to abort stuck accesses.
module wb_dma_copy #(
    parameter int AW      = 30,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic [AW-1:0]    i_src,
    input  logic [AW-1:0]    i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [AW-1:0]    wb_addr,
    output logic [31:0]      wb_mosi,
    output logic [3:0]       wb_sel,
    input  logic             wb_ack,
    input  logic             wb_stall,
    input  logic             wb_err,
    input  logic [31:0]      wb_miso
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_GAP, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    src_ptr, dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      data_buf;
    logic             load, capture, advance, abort, bus_err;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_cnt;
    logic          enter_req, in_bus;

    assign enter_req = (state_nxt == S_RD_REQ || state_nxt == S_WR_REQ) && (state_nxt != state);
    assign in_bus    = wb_cyc;
    // A late ack on the final cycle still completes the access normally.
    assign bus_err   = wb_err || ((tmo_cnt == TW'(TIMEOUT - 1)) && !wb_ack);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)      tmo_cnt <= '0;
        else if (enter_req) tmo_cnt <= '0;
        else if (in_bus)    tmo_cnt <= tmo_cnt + TW'(1);
    end
`else
    assign bus_err = wb_err;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        abort     = 1'b0;
        unique case (state)
            S_IDLE: if (i_start) begin
                load      = 1'b1;
                state_nxt = (i_len == '0) ? S_DONE : S_RD_REQ;
            end
            S_RD_REQ: begin
                if (bus_err) abort = 1'b1;
                else if (!wb_stall) begin
                    // An ack in the accepting cycle is the response itself.
                    capture   = wb_ack;
                    state_nxt = wb_ack ? S_WR_REQ : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus_err) abort = 1'b1;
                else if (wb_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (bus_err) abort = 1'b1;
                else if (!wb_stall) begin
                    advance   = wb_ack;
                    state_nxt = wb_ack ? S_GAP : S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (bus_err) abort = 1'b1;
                else if (wb_ack) begin
                    advance   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = (remaining != '0) ? S_RD_REQ : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_DONE;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
            o_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state <= state_nxt;
            if (load) begin
                src_ptr   <= i_src;
                dst_ptr   <= i_dst;
                remaining <= i_len;
                o_err     <= 1'b0;
            end
            if (capture) data_buf <= wb_miso;
            if (advance) begin
                src_ptr   <= src_ptr + AW'(1);
                dst_ptr   <= dst_ptr + AW'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (abort) o_err <= 1'b1;
        end
    end

    // Bus outputs decode straight from state so reset drops cyc/stb immediately.
    assign wb_cyc  = (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                     (state == S_WR_REQ) || (state == S_WR_WAIT);
    assign wb_stb  = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign wb_we   = (state == S_WR_REQ);
    assign wb_addr = (state == S_RD_REQ) ? src_ptr :
                     (state == S_WR_REQ) ? dst_ptr : '0;
    assign wb_mosi = (state == S_WR_REQ) ? data_buf : '0;
    assign wb_sel  = 4'hF;
    assign o_busy  = (state != S_IDLE) && (state != S_DONE);
    assign o_done  = (state == S_DONE);

endmodule
